bpu_bht: RTL and testbench
==========================

# bpu_bht

Dynamic branch predictor for the IFU: a direct-mapped branch target buffer with 2-bit saturating direction counters. In IF it predicts taken/not-taken and the next-fetch target for the current fetch PC; this prediction travels down the pipe as `ex_pred_taken`. In EX it is trained with the resolved outcome and target once the branch control logic has resolved the jump. It also keeps a saturating mispredict performance counter.

## Interface
- `ENTRIES`, 64: number of BTB entries; power of two. `IDX_W = log2(ENTRIES)`.
- `TAG_W`, 8: tag bits taken from the PC above the index.

Ports:
- `clk`  in  1  clock, posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `if_pc`  in  32  fetch PC to predict.
- `if_pred_taken`  out  1  predicted taken.
- `if_pred_target`  out  32  predicted next PC.
- `ex_upd_en`  in  1  EX holds a resolved jump; one pulse per instruction, already gated by stall and kill.
- `ex_pc`  in  32  PC of the resolved jump.
- `ex_is_branch`  in  1  1 = conditional branch; 0 = `j`, `jal`, `jr`, `jalr`.
- `ex_act_taken`  in  1  resolved direction.
- `ex_act_target`  in  32  resolved target; valid when `ex_act_taken`.
- `ex_flush_req`  in  1  mispredict indication from EX.
- `perf_mispred`  out  32  mispredict count.

## Operation
- **Index and tag**
  - index = `pc[IDX_W+1:2]`.
  - tag = `pc[IDX_W+TAG_W+1:IDX_W+2]`.
- **Entry contents:** valid, tag, target[31:0], cnt[1:0].
  - Counter encodings: SNT=00, WNT=01, WT=10, ST=11.
- **Lookup (combinational)**
  - hit = valid & tag match.
  - `if_pred_taken` = hit & cnt[1].
  - `if_pred_target` = `if_pred_taken` ? entry target : `if_pc + 32'd4`. The add wraps modulo 2^32.
- **Update** (only when `ex_upd_en`):
  - Hit, conditional:
    - taken: cnt increments, saturating at 11; target is overwritten.
    - not taken: cnt decrements, saturating at 00; target is unchanged.
  - Hit, unconditional: cnt = 11; target is overwritten. The `jr` target can change between executions.
  - Miss, taken: allocate the entry, replacing any alias.
    - Set valid=1, write tag and target.
    - cnt = 10 for a conditional branch, 11 for an unconditional jump.
  - Miss, not taken: no change.
- **Perf counter:** `perf_mispred` increments when `ex_upd_en & ex_flush_req`, saturating at 32'hFFFF_FFFF. `ex_flush_req` without `ex_upd_en` is ignored.

## Timing
- Lookup has zero latency: outputs depend only on `if_pc` and the array state.
- An update is written at the posedge where `ex_upd_en` is sampled. It is visible to lookups from the next cycle.
- Update and lookup to the same index in the same cycle: the lookup sees the pre-update state. There is no bypass.
- Only one update per cycle, so there are no write conflicts.
- Reset, asynchronous and also mid-operation:
  - all valid = 0;
  - all cnt = 01;
  - all tags and targets = 0;
  - `perf_mispred` = 0.
- While reset is asserted: `if_pred_taken` = 0 and `if_pred_target` = `if_pc + 4`.
- The first update is accepted at the first posedge after `rst` deasserts.

## Structure
- Shared include `bpu_def.v`, placed beside `branch_def.v`, holds:
  - the counter encodings `BPU_CNT_SNT`, `BPU_CNT_WNT`, `BPU_CNT_WT`, `BPU_CNT_ST`;
  - the reset value `BPU_CNT_RST` (= WNT);
  - the allocation values for conditional and unconditional jumps.
- Sub-module `bpu_sat_cnt`: combinational next-state for the 2-bit counter. Inputs: cnt, taken, force_st. Output: next cnt.
- Storage uses flops, not RAM, because reset must clear the whole array asynchronously.

## Test plan
All cases use defaults: index = `pc[7:2]`, tag = `pc[15:8]`.

1. **Cold lookup:** after reset, `if_pc`=0x00400010 -> `if_pred_taken`=0, target=0x00400014, `perf_mispred`=0.
2. **Wrap-around:** `if_pc`=0xFFFFFFFC, cold -> target=0x00000000.
3. **Allocate and saturate:**
   - Update `ex_pc`=0x00400010, conditional, taken, target 0x00400100 -> next cycle lookup of 0x00400010 gives taken, 0x00400100 (cnt=10).
   - Two more taken updates -> cnt saturates at 11.
   - Then one not-taken update -> still predicts taken (10).
   - Then a second not-taken update -> predicts not taken (01).
4. **Aliasing:**
   - Entry for 0x00400010 valid; update taken at 0x00400410 (same index 0x04, tag 0x04), target 0x00401000.
   - Lookup of 0x00400010 -> miss, not taken, target 0x00400014.
   - Lookup of 0x00400410 -> taken, target 0x00401000.
5. **Unconditional jump and same-cycle read:**
   - Unconditional `jr` update at 0x00400020 with target 0x00400200, while `if_pc`=0x00400020 in the same cycle.
   - That cycle's lookup: not taken.
   - Next cycle: taken, target 0x00400200.
   - A second update with target 0x00400300 -> target changes to 0x00400300.
6. **Perf counter and reset:**
   - Three `ex_upd_en & ex_flush_req` pulses plus one `ex_flush_req` without `ex_upd_en` -> `perf_mispred`=3.
   - Assert `rst` mid-cycle -> `perf_mispred`=0 immediately, and all entries miss.

Source files
------------

// File: rtl/bpu_bht_pkg.sv
// ============================================================================
// bpu_bht_pkg : counter encodings and allocation values for the BTB predictor
// Revision    : 1.0
// ============================================================================
`default_nettype none

package bpu_bht_pkg;

   localparam logic [1:0] BPU_CNT_SNT          = 2'b00;
   localparam logic [1:0] BPU_CNT_WNT          = 2'b01;
   localparam logic [1:0] BPU_CNT_WT           = 2'b10;
   localparam logic [1:0] BPU_CNT_ST           = 2'b11;
   localparam logic [1:0] BPU_CNT_RST          = BPU_CNT_WNT;
   localparam logic [1:0] BPU_CNT_ALLOC_COND   = BPU_CNT_WT;
   localparam logic [1:0] BPU_CNT_ALLOC_UNCOND = BPU_CNT_ST;

endpackage

`default_nettype wire

// File: rtl/bpu_sat_cnt.sv
// ============================================================================
// bpu_sat_cnt : next-state of a 2-bit saturating direction counter
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bpu_sat_cnt
   import bpu_bht_pkg::*;
(
   input  logic [1:0] cnt_i,
   input  logic       taken_i,
   input  logic       force_st_i,
   output logic [1:0] cnt_o
);

   always_comb begin
      cnt_o = cnt_i;
      if (force_st_i) begin
         cnt_o = BPU_CNT_ST;
      end else if (taken_i) begin
         if (cnt_i != BPU_CNT_ST) cnt_o = cnt_i + 2'd1;
      end else begin
         if (cnt_i != BPU_CNT_SNT) cnt_o = cnt_i - 2'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/bpu_bht.sv
// ============================================================================
// bpu_bht : direct-mapped BTB with 2-bit direction counters and mispredict count
// Revision : 1.0
// ============================================================================
`default_nettype none

module bpu_bht
   import bpu_bht_pkg::*;
#(
   parameter int ENTRIES = 64,
   parameter int TAG_W   = 8
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   output logic        if_pred_taken,
   output logic [31:0] if_pred_target,
   input  logic        ex_upd_en,
   input  logic [31:0] ex_pc,
   input  logic        ex_is_branch,
   input  logic        ex_act_taken,
   input  logic [31:0] ex_act_target,
   input  logic        ex_flush_req,
   output logic [31:0] perf_mispred
);

   localparam int IDX_W = $clog2(ENTRIES);

   logic              valid_q  [ENTRIES];
   logic [TAG_W-1:0]  tag_q    [ENTRIES];
   logic [31:0]       target_q [ENTRIES];
   logic [1:0]        cnt_q    [ENTRIES];
   logic [31:0]       perf_q;
   logic [31:0]       perf_d;

   logic [IDX_W-1:0]  w_if_idx;
   logic [TAG_W-1:0]  w_if_tag;
   logic              w_if_hit;
   logic [IDX_W-1:0]  w_ex_idx;
   logic [TAG_W-1:0]  w_ex_tag;
   logic              w_ex_hit;
   logic [1:0]        w_cnt_nxt;
   logic              w_unused_ok;

   assign w_if_idx = if_pc[IDX_W+1:2];
   assign w_if_tag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign w_ex_idx = ex_pc[IDX_W+1:2];
   assign w_ex_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign w_unused_ok = ^{ex_pc[31:IDX_W+TAG_W+2], ex_pc[1:0]};

   // Lookup is purely combinational and deliberately ignores any update in flight.
   assign w_if_hit       = valid_q[w_if_idx] && (tag_q[w_if_idx] == w_if_tag);
   assign if_pred_taken  = !rst && w_if_hit && cnt_q[w_if_idx][1];
   assign if_pred_target = if_pred_taken ? target_q[w_if_idx] : (if_pc + 32'd4);

   assign w_ex_hit = valid_q[w_ex_idx] && (tag_q[w_ex_idx] == w_ex_tag);

   bpu_sat_cnt u_sat_cnt (
      .cnt_i      (cnt_q[w_ex_idx]),
      .taken_i    (ex_act_taken),
      .force_st_i (!ex_is_branch),
      .cnt_o      (w_cnt_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            cnt_q[i]    <= BPU_CNT_RST;
         end
      end else if (ex_upd_en) begin
         if (w_ex_hit) begin
            cnt_q[w_ex_idx] <= w_cnt_nxt;
            if (ex_act_taken || !ex_is_branch) target_q[w_ex_idx] <= ex_act_target;
         end else if (ex_act_taken) begin
            // Allocation evicts whatever alias currently owns the slot.
            valid_q[w_ex_idx]  <= 1'b1;
            tag_q[w_ex_idx]    <= w_ex_tag;
            target_q[w_ex_idx] <= ex_act_target;
            cnt_q[w_ex_idx]    <= ex_is_branch ? BPU_CNT_ALLOC_COND : BPU_CNT_ALLOC_UNCOND;
         end
      end
   end

   always_comb begin
      perf_d = perf_q;
      if (ex_upd_en && ex_flush_req && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) perf_q <= '0;
      else     perf_q <= perf_d;
   end

   assign perf_mispred = perf_q;

endmodule

`default_nettype wire

// File: tb/tb_bpu_bht.sv
// ============================================================================
// tb_bpu_bht : directed vector bench for bpu_bht
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_bpu_bht;

   typedef struct {
      logic [31:0] if_pc;
      logic        upd;
      logic [31:0] ex_pc;
      logic        br;
      logic        tk;
      logic [31:0] tgt;
      logic        fl;
      logic        e_tk;
      logic [31:0] e_tgt;
      logic [31:0] e_perf;
   } vec_t;

   localparam int NV = 24;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] if_pc = 32'h0040_0010;
   logic        if_pred_taken;
   logic [31:0] if_pred_target;
   logic        ex_upd_en = 1'b0;
   logic [31:0] ex_pc = '0;
   logic        ex_is_branch = 1'b0;
   logic        ex_act_taken = 1'b0;
   logic [31:0] ex_act_target = '0;
   logic        ex_flush_req = 1'b0;
   logic [31:0] perf_mispred;

   int checks = 0;
   int errors = 0;
   vec_t vecs [NV];

   always #5 clk = ~clk;

   bpu_bht dut (
      .clk            (clk),
      .rst            (rst),
      .if_pc          (if_pc),
      .if_pred_taken  (if_pred_taken),
      .if_pred_target (if_pred_target),
      .ex_upd_en      (ex_upd_en),
      .ex_pc          (ex_pc),
      .ex_is_branch   (ex_is_branch),
      .ex_act_taken   (ex_act_taken),
      .ex_act_target  (ex_act_target),
      .ex_flush_req   (ex_flush_req),
      .perf_mispred   (perf_mispred)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] pc, input logic upd, input logic [31:0] epc,
                               input logic br, input logic tk, input logic [31:0] tgt,
                               input logic fl, input logic etk, input logic [31:0] etgt,
                               input logic [31:0] eperf);
      vec_t v;
      v.if_pc = pc; v.upd = upd; v.ex_pc = epc; v.br = br; v.tk = tk; v.tgt = tgt;
      v.fl = fl; v.e_tk = etk; v.e_tgt = etgt; v.e_perf = eperf;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      if_pc = v.if_pc; ex_upd_en = v.upd; ex_pc = v.ex_pc; ex_is_branch = v.br;
      ex_act_taken = v.tk; ex_act_target = v.tgt; ex_flush_req = v.fl;
   endtask

   initial begin
      // Expected outputs reflect the array state before the vector's own update lands.
      vecs[0]  = mk(32'h0040_0010, 0, 0, 0, 0, 0, 0,                      0, 32'h0040_0014, 0);
      vecs[1]  = mk(32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0,                      0, 32'h0000_0000, 0);
      vecs[2]  = mk(32'h0040_0010, 1, 32'h0040_0010, 1, 1, 32'h0040_0100, 0, 0, 32'h0040_0014, 0);
      vecs[3]  = mk(32'h0040_0010, 1, 32'h0040_0010, 1, 1, 32'h0040_0100, 0, 1, 32'h0040_0100, 0);
      vecs[4]  = mk(32'h0040_0010, 1, 32'h0040_0010, 1, 1, 32'h0040_0100, 0, 1, 32'h0040_0100, 0);
      vecs[5]  = mk(32'h0040_0010, 1, 32'h0040_0010, 1, 0, 32'hDEAD_0000, 0, 1, 32'h0040_0100, 0);
      vecs[6]  = mk(32'h0040_0010, 1, 32'h0040_0010, 1, 0, 32'hDEAD_0000, 0, 1, 32'h0040_0100, 0);
      vecs[7]  = mk(32'h0040_0010, 0, 0, 0, 0, 0, 0,                      0, 32'h0040_0014, 0);
      vecs[8]  = mk(32'h0040_0410, 1, 32'h0040_0410, 1, 1, 32'h0040_1000, 0, 0, 32'h0040_0414, 0);
      vecs[9]  = mk(32'h0040_0010, 0, 0, 0, 0, 0, 0,                      0, 32'h0040_0014, 0);
      vecs[10] = mk(32'h0040_0410, 0, 0, 0, 0, 0, 0,                      1, 32'h0040_1000, 0);
      vecs[11] = mk(32'h0040_0020, 1, 32'h0040_0020, 0, 1, 32'h0040_0200, 0, 0, 32'h0040_0024, 0);
      vecs[12] = mk(32'h0040_0020, 1, 32'h0040_0020, 0, 1, 32'h0040_0300, 0, 1, 32'h0040_0200, 0);
      vecs[13] = mk(32'h0040_0020, 0, 0, 0, 0, 0, 0,                      1, 32'h0040_0300, 0);
      vecs[14] = mk(32'h0040_0030, 1, 32'h0040_0030, 1, 0, 32'h0040_0999, 0, 0, 32'h0040_0034, 0);
      vecs[15] = mk(32'h0040_0030, 0, 0, 0, 0, 0, 0,                      0, 32'h0040_0034, 0);
      vecs[16] = mk(32'h0040_0410, 1, 32'h0040_0030, 1, 0, 32'h0040_0999, 1, 1, 32'h0040_1000, 0);
      vecs[17] = mk(32'h0040_0410, 1, 32'h0040_0030, 1, 0, 32'h0040_0999, 1, 1, 32'h0040_1000, 1);
      vecs[18] = mk(32'h0040_0410, 1, 32'h0040_0030, 1, 0, 32'h0040_0999, 1, 1, 32'h0040_1000, 2);
      vecs[19] = mk(32'h0040_0410, 0, 32'h0040_0030, 1, 0, 32'h0040_0999, 1, 1, 32'h0040_1000, 3);
      vecs[20] = mk(32'h0040_0410, 0, 0, 0, 0, 0, 0,                      1, 32'h0040_1000, 3);
      vecs[21] = mk(32'h0040_0040, 1, 32'h0040_0040, 0, 1, 32'h0040_0500, 0, 0, 32'h0040_0044, 3);
      vecs[22] = mk(32'h0040_0040, 1, 32'h0040_0040, 1, 0, 32'h0040_0777, 0, 1, 32'h0040_0500, 3);
      vecs[23] = mk(32'h0040_0040, 0, 0, 0, 0, 0, 0,                      1, 32'h0040_0500, 3);

      #2;
      chk("rst_taken",  {31'd0, if_pred_taken}, 32'd0);
      chk("rst_target", if_pred_target, 32'h0040_0014);
      chk("rst_perf",   perf_mispred, 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(posedge clk); #1;
         apply(vecs[i]);
         #1;
         chk($sformatf("v%0d_taken", i),  {31'd0, if_pred_taken}, {31'd0, vecs[i].e_tk});
         chk($sformatf("v%0d_target", i), if_pred_target, vecs[i].e_tgt);
         chk($sformatf("v%0d_perf", i),   perf_mispred, vecs[i].e_perf);
      end

      // Asynchronous reset in the middle of a cycle clears everything at once.
      @(posedge clk); #1;
      apply(mk(32'h0040_0040, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #1;
      chk("pre_rst_taken", {31'd0, if_pred_taken}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_perf",   perf_mispred, 32'd0);
      chk("mid_rst_taken",  {31'd0, if_pred_taken}, 32'd0);
      chk("mid_rst_target", if_pred_target, 32'h0040_0044);
      if_pc = 32'h0040_0410;
      #1;
      chk("mid_rst_alias_miss", {31'd0, if_pred_taken}, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_miss", {31'd0, if_pred_taken}, 32'd0);

      // First update after reset release must be accepted at the very next posedge.
      apply(mk(32'h0040_0050, 1, 32'h0040_0050, 0, 1, 32'h0040_0600, 0, 0, 0, 0));
      @(posedge clk); #1;
      ex_upd_en = 1'b0;
      #1;
      chk("first_upd_taken",  {31'd0, if_pred_taken}, 32'd1);
      chk("first_upd_target", if_pred_target, 32'h0040_0600);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
